// File: rtl/mac_pkg.sv
// Shared types for the MAC operand feeder: sequencer states, default sizing,
// and the packed weight/activation pair.
package mac_pkg;

  localparam int N_DEF     = 8;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    HOLD
  } state_t;

  typedef struct packed {
    logic signed [N_DEF-1:0] w;
    logic signed [N_DEF-1:0] x;
  } pair_t;

endpackage

// File: rtl/mac_feeder_buf.sv
// Operand buffer: DEPTH entries of {w, x}, one synchronous write port and one
// combinational read port driven by the stream counter.
module mac_feeder_buf
  import mac_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [N-1:0]             wr_w,
  input  logic [N-1:0]             wr_x,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [N-1:0]             rd_w,
  output logic [N-1:0]             rd_x
);

  logic [2*N-1:0] mem_q [DEPTH];

  // NOTE: storage arrays carry no reset; resetting them would turn the array
  // into DEPTH*2N individually reset flops, and nothing reads an entry before
  // the controller has written it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= {wr_w, wr_x};
    end
  end

  assign rd_w = mem_q[rd_addr][2*N-1:N];
  assign rd_x = mem_q[rd_addr][N-1:0];

endmodule

// File: rtl/mac_feeder.sv
// Operand sequencer / result collector driving one mac_Nbits accumulator.
// Optional MAC_FEEDER_OVF_EN adds a wide shadow sum and a res_ovf flag.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [N-1:0]             wr_w,
  input  logic [N-1:0]             wr_x,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   len,
  output logic                     busy,
  output logic                     mac_rst_n,
  output logic                     mac_en,
  output logic [N-1:0]             mac_w,
  output logic [N-1:0]             mac_x,
  input  logic [2*N-1:0]           mac_out,
  output logic                     res_valid,
  input  logic                     res_ready,
`ifdef MAC_FEEDER_OVF_EN
  output logic                     res_ovf,
`endif
  output logic [2*N-1:0]           res_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  state_t         state_q,     state_d;
  logic [LW-1:0]  cnt_len_q,   cnt_len_d;
  logic [LW-1:0]  idx_q,       idx_d;
  logic           mac_rst_n_q, mac_rst_n_d;
  logic           mac_en_q,    mac_en_d;
  logic [N-1:0]   mac_w_q,     mac_w_d;
  logic [N-1:0]   mac_x_q,     mac_x_d;
  logic [2*N-1:0] res_data_q,  res_data_d;
  logic [N-1:0]   rd_w, rd_x;

  mac_feeder_buf #(.N(N), .DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en && (state_q == IDLE)),
    .wr_addr (wr_addr),
    .wr_w    (wr_w),
    .wr_x    (wr_x),
    .rd_addr (idx_q[AW-1:0]),
    .rd_w    (rd_w),
    .rd_x    (rd_x)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_len_d  = cnt_len_q;
    idx_d      = idx_q;
    res_data_d = res_data_q;
    mac_w_d    = '0;
    mac_x_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_len_d = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
          idx_d     = '0;
          state_d   = CLEAR;
        end
      end
      CLEAR:  state_d = (cnt_len_q != '0) ? STREAM : DRAIN;
      STREAM: if (idx_q == cnt_len_q) state_d = DRAIN;
      DRAIN: begin
        res_data_d = mac_out;
        state_d    = HOLD;
      end
      HOLD:   if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // MAC-facing outputs are registered, so they are derived from the state
    // being entered; idx_q counts pairs already issued.
    if (state_d == STREAM) begin
      mac_w_d = rd_w;
      mac_x_d = rd_x;
      idx_d   = idx_q + LW'(1);
    end
    mac_en_d    = (state_d == STREAM);
    mac_rst_n_d = (state_d != CLEAR);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_len_q   <= '0;
      idx_q       <= '0;
      mac_rst_n_q <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_w_q     <= '0;
      mac_x_q     <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_len_q   <= cnt_len_d;
      idx_q       <= idx_d;
      mac_rst_n_q <= mac_rst_n_d;
      mac_en_q    <= mac_en_d;
      mac_w_q     <= mac_w_d;
      mac_x_q     <= mac_x_d;
      res_data_q  <= res_data_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == HOLD);
  assign mac_rst_n = mac_rst_n_q;
  assign mac_en    = mac_en_q;
  assign mac_w     = mac_w_q;
  assign mac_x     = mac_x_q;
  assign res_data  = res_data_q;

`ifdef MAC_FEEDER_OVF_EN
  localparam int SW = 2 * N + AW;

  logic signed [SW-1:0]  shadow_q, shadow_d;
  logic                  res_ovf_q, res_ovf_d;
  logic signed [2*N-1:0] prod;
  logic [AW:0]           shadow_top;

  // Mirrors the MAC's timing: it accumulates exactly the pairs it sees with en.
  always_comb begin
    prod       = $signed(mac_w_q) * $signed(mac_x_q);
    shadow_top = shadow_q[SW-1:2*N-1];
    shadow_d   = shadow_q;
    res_ovf_d  = res_ovf_q;
    if (state_q == CLEAR) begin
      shadow_d = '0;
    end else if (mac_en_q) begin
      shadow_d = shadow_q + SW'(prod);
    end
    if (state_q == DRAIN) begin
      res_ovf_d = !((&shadow_top) || (~|shadow_top));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign res_ovf = res_ovf_q;
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder with a behavioural mac_Nbits attached;
// a timeline model derived from the start/length rules is compared every cycle.
module tb_mac_feeder;
  import mac_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               wr_en = 1'b0;
  logic [2:0]         wr_addr = '0;
  logic [7:0]         wr_w = '0;
  logic [7:0]         wr_x = '0;
  logic               start = 1'b0;
  logic [3:0]         len = '0;
  logic               busy, mac_rst_n, mac_en, res_valid;
  logic               res_ready = 1'b0;
  logic [7:0]         mac_w, mac_x;
  logic signed [15:0] mac_out;
  logic signed [15:0] res_data;
`ifdef MAC_FEEDER_OVF_EN
  logic               res_ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int en_cnt   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mac_feeder #(.N(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_w      (wr_w),
    .wr_x      (wr_x),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .mac_rst_n (mac_rst_n),
    .mac_en    (mac_en),
    .mac_w     (mac_w),
    .mac_x     (mac_x),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
`ifdef MAC_FEEDER_OVF_EN
    .res_ovf   (res_ovf),
`endif
    .res_data  (res_data)
  );

  // Behavioural mac_Nbits: async active-low clear, wrapping 2N accumulate.
  always_ff @(posedge clk or negedge mac_rst_n) begin
    if (!mac_rst_n)  mac_out <= '0;
    else if (mac_en) mac_out <= mac_out + ($signed(mac_w) * $signed(mac_x));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)",
               name, $time, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Reference model: k counts edges since the start edge. k=0 clear cycle,
  // k=1..L stream pair k-1, k=L+1 drain, k>=L+2 result held until taken.
  pair_t              mbuf [8];
  int                 m_k = -1;
  int                 m_len = 0;
  logic signed [15:0] m_res = '0;
  logic signed [15:0] m_data = '0;
  bit                 exp_busy, exp_rstn, exp_en, exp_valid;
  logic [7:0]         exp_w, exp_x;

  function automatic logic signed [15:0] dot(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(mbuf[i].w) * longint'(mbuf[i].x);
    return 16'(s);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_k      = -1;
      m_data   = '0;
      exp_rstn = 1'b0;
    end else begin
      if (m_k < 0) begin
        if (wr_en) mbuf[wr_addr] = '{w: wr_w, x: wr_x};
        if (start) begin
          m_len = (int'(len) > 8) ? 8 : int'(len);
          m_res = dot(m_len);
          m_k   = 0;
        end
      end else if (m_k >= m_len + 2 && res_ready) begin
        m_k = -1;
      end else begin
        m_k++;
      end
      exp_rstn = (m_k != 0);
    end
    exp_busy  = (m_k >= 0);
    exp_en    = (m_k >= 1) && (m_k <= m_len);
    exp_valid = (m_k >= m_len + 2);
    if (m_k == m_len + 2) m_data = m_res;
    exp_w = exp_en ? mbuf[m_k-1].w : 8'd0;
    exp_x = exp_en ? mbuf[m_k-1].x : 8'd0;
  end

  always @(negedge clk) begin
    if (mac_en) en_cnt++;
    if (chk_en) begin
      check("busy",      32'(busy),      32'(exp_busy));
      check("mac_rst_n", 32'(mac_rst_n), 32'(exp_rstn));
      check("mac_en",    32'(mac_en),    32'(exp_en));
      check("res_valid", 32'(res_valid), 32'(exp_valid));
      check("res_data",  32'(res_data),  32'(m_data));
      if (mac_en && !mac_rst_n) check("clear_while_en", 32'(1), 32'(0));
      if (exp_en) begin
        check("mac_w", 32'(mac_w), 32'(exp_w));
        check("mac_x", 32'(mac_x), 32'(exp_x));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int a, input int w, input int x);
    wr_en = 1'b1; wr_addr = 3'(a); wr_w = 8'(w); wr_x = 8'(x);
    tick();
    wr_en = 1'b0;
  endtask

  // Launch a run, measure start-to-valid latency, optionally poke a write
  // during STREAM and a start during HOLD, then complete the handshake.
  task automatic run(input string tag, input int l, input int hold,
                     input bit poke_wr, input bit poke_st,
                     input int exp_lat, input int exp_ens, input int exp_data);
    int cyc = 0;
    start = 1'b1; len = 4'(l);
    tick();
    start  = 1'b0;
    en_cnt = 0;
    while (!res_valid && cyc < 100) begin
      wr_en = poke_wr && (cyc == 1);
      wr_addr = 3'd2; wr_w = 8'd100; wr_x = 8'd100;
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_data"}, 32'(res_data), 32'(exp_data));
    for (int i = 0; i < hold; i++) begin
      start = poke_st && (i == 0);
      tick();
      check({tag, "_hold_busy"}, 32'(busy), 32'(1));
    end
    start = 1'b0;
    check({tag, "_data_stable"}, 32'(res_data), 32'(exp_data));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_busy_after"}, 32'(busy), 32'(0));
    check({tag, "_mac_en_cycles"}, 32'(en_cnt), 32'(exp_ens));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_busy",      32'(busy),      32'(0));
    check("rst_mac_en",    32'(mac_en),    32'(0));
    check("rst_mac_rst_n", 32'(mac_rst_n), 32'(0));
    check("rst_res_valid", 32'(res_valid), 32'(0));
    check("rst_res_data",  32'(res_data),  32'(0));
    check("rst_mac_w",     32'(mac_w),     32'(0));
    rst = 1'b0;
    tick();
    check("idle_mac_rst_n", 32'(mac_rst_n), 32'(1));

    // Basic two-pair product: -3*2 + 5*-4 = -26
    write(0, -3, 2);
    write(1, 5, -4);
    run("len2", 2, 0, 0, 0, 4, 2, -26);
`ifdef MAC_FEEDER_OVF_EN
    check("len2_ovf", 32'(res_ovf), 32'(0));
`endif

    // Zero-length vector
    run("len0", 0, 0, 0, 0, 2, 0, 0);

    // Abort on the second STREAM cycle
    write(2, 7, 3);
    start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy",      32'(busy),      32'(0));
    check("abort_mac_en",    32'(mac_en),    32'(0));
    check("abort_res_valid", 32'(res_valid), 32'(0));
    run("rerun", 2, 0, 0, 0, 4, 2, -26);

    // 6*-8 + -8*-4 + 1*1 = -15, result held for 5 cycles
    write(0, 6, -8);
    write(1, -8, -4);
    write(2, 1, 1);
    run("len3_hold", 3, 5, 0, 0, 5, 3, -15);

    // Write during STREAM and start during HOLD are both ignored
    run("ignore", 3, 2, 1, 1, 5, 3, -15);
    run("ignore_rerun", 3, 0, 0, 0, 5, 3, -15);

    // 8 * 16384 = 2^17 wraps to 0 in 16 bits
    for (int i = 0; i < 8; i++) write(i, -128, -128);
    run("wrap", 8, 0, 0, 0, 10, 8, 0);
`ifdef MAC_FEEDER_OVF_EN
    check("wrap_ovf", 32'(res_ovf), 32'(1));
`endif

    // len=15 clamps to 8: sum of (i+1)*1 = 36
    for (int i = 0; i < 8; i++) write(i, i + 1, 1);
    run("clamp", 15, 0, 0, 0, 10, 8, 36);

    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Operand sequencer and result collector on the driving side of the mac_Nbits accumulator interface.
- Holds a weight/activation vector pair in a local register buffer, clears the MAC, and streams one W/X pair per cycle with en asserted.
- Waits out the MAC's one-cycle accumulate latency, then returns the dot product on a valid/ready result port.
- Sits between the layer controller (buffer load and start) and one mac_Nbits instance.

Parameters:
- N, 8, operand width in bits (signed); result width is 2N.
- DEPTH, 8, buffer entries, i.e. the maximum vector length; power of 2, at least 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  $clog2(DEPTH)  buffer write index.
- wr_w  in  N  signed weight to store.
- wr_x  in  N  signed activation to store.
- start  in  1  single-cycle pulse that launches a dot product.
- len  in  $clog2(DEPTH)+1  vector length, sampled on the start cycle.
- busy  out  1  high from start acceptance until the result handshake completes.
- mac_rst_n  out  1  active-low clear to the MAC's rst.
- mac_en  out  1  MAC accumulate enable.
- mac_w  out  N  signed weight to the MAC's W.
- mac_x  out  N  signed activation to the MAC's X.
- mac_out  in  2N  MAC accumulator value from the MAC's Out.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  2N  signed dot product.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - busy=0, mac_en=0, mac_rst_n=0, mac_w=0, mac_x=0, res_valid=0, res_data=0.
  - Buffer contents are not cleared.
- All MAC-facing outputs are registered.
- States:
  - IDLE: mac_rst_n=1, mac_en=0. Writes with wr_en=1 update buf[wr_addr]. On start=1, latch len into cnt_len and go to CLEAR. A write and a start in the same cycle: the write lands and that entry is used.
  - CLEAR: one cycle with mac_rst_n=0 and mac_en=0, so the MAC's Out reads 0. Next state is STREAM if cnt_len>0, otherwise DRAIN.
  - STREAM: cnt_len cycles with mac_rst_n=1 and mac_en=1. In cycle i (i=0..cnt_len-1), mac_w=buf[i].w and mac_x=buf[i].x. After the last pair, go to DRAIN.
  - DRAIN: one cycle with mac_en=0 and mac_w=mac_x=0. The final accumulate is visible on mac_out during this cycle. Capture mac_out into res_data, then go to HOLD.
  - HOLD: res_valid=1 and res_data stable. When res_valid and res_ready are both 1 at an edge, go to IDLE with busy=0 and res_valid=0. res_ready is ignored outside HOLD.
- Length rules:
  - len=0 gives res_data=0 after the CLEAR→DRAIN→HOLD path.
  - len>DEPTH is clamped to DEPTH.
- Latency: start accepted at edge E0 → res_valid first high after edge E0+len+2.
- Arithmetic is done by the MAC. The feeder does no arithmetic on data; the result is 2N-bit two's complement and wraps as the MAC wraps.
- Boundary conditions:
  - start while busy is ignored.
  - wr_en while busy is ignored, so the buffer is frozen during a run.
  - rst mid-run aborts immediately. The next cycle is IDLE with mac_en=0, and no result is produced.
  - The MAC is cleared only in CLEAR and never while mac_en=1.

Optional Feature:
- Macro: MAC_FEEDER_OVF_EN.
- Defined:
  - A shadow accumulator of 2N+$clog2(DEPTH) bits sums sign-extended buf[i].w*buf[i].x during STREAM.
  - Extra output port res_ovf (out, 1) is captured in DRAIN. It is 1 when the shadow value is outside the signed 2N range, and is held with res_valid.
  - rst clears res_ovf and the shadow accumulator to 0.
- Undefined: no res_ovf port and no shadow logic.

Decomposition:
- Package mac_pkg holds:
  - State enum (IDLE, CLEAR, STREAM, DRAIN, HOLD).
  - Default N and DEPTH localparams.
  - A packed operand-pair typedef {w, x}.
- One sub-module, mac_feeder_buf: DEPTH-entry register file with one synchronous write port and one combinational read port indexed by the stream counter.
- The FSM, counters and handshake stay in mac_feeder.

Test Plan (N=8, DEPTH=8, mac_Nbits instance wired to the MAC-facing ports):
- Load buf[0]=(-3,2), buf[1]=(5,-4); start with len=2 → mac_en high for exactly 2 cycles; res_valid after E0+4; res_data=-26.
- Load (6,-8),(-8,-4),(1,1); len=3; hold res_ready=0 for 5 cycles → res_data=-15, stable, with busy=1 throughout; res_ready=1 → busy=0 the next cycle.
- start with len=0 → res_data=0 after E0+2; mac_en never asserted.
- rst=1 on the second STREAM cycle → next cycle busy=0, mac_en=0, res_valid=0. A rerun with len=2 on the earlier vector returns -26 (MAC was cleared).
- start pulse while in HOLD, and wr_en while in STREAM → both ignored; buffer contents and result unchanged.
- With MAC_FEEDER_OVF_EN: 8 pairs of (-128,-128) → res_data wraps to 0 and res_ovf=1; the -26 case gives res_ovf=0.
